// File: rtl/arithmetic_logic_unit.sv
// Register-file-fed ALU: single-cycle arithmetic/logic/shift ops plus an
// iterative 16x16 shift-add multiplier, with a registered {Z,C,N,O} flag set.
module arithmetic_logic_unit #(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       FunSel,
    input  logic             WF,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUOut,
    output logic [3:0]       FlagsOut
);

    localparam int CNT_W = $clog2(MUL_ITER);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

    localparam logic [4:0] FS_A    = 5'b00000;
    localparam logic [4:0] FS_B    = 5'b00001;
    localparam logic [4:0] FS_NA   = 5'b00010;
    localparam logic [4:0] FS_NB   = 5'b00011;
    localparam logic [4:0] FS_ADD  = 5'b00100;
    localparam logic [4:0] FS_ADC  = 5'b00101;
    localparam logic [4:0] FS_SUB  = 5'b00110;
    localparam logic [4:0] FS_AND  = 5'b00111;
    localparam logic [4:0] FS_OR   = 5'b01000;
    localparam logic [4:0] FS_XOR  = 5'b01001;
    localparam logic [4:0] FS_NAND = 5'b01010;
    localparam logic [4:0] FS_LSL  = 5'b01011;
    localparam logic [4:0] FS_LSR  = 5'b01100;
    localparam logic [4:0] FS_ASR  = 5'b01101;
    localparam logic [4:0] FS_CSL  = 5'b01110;
    localparam logic [4:0] FS_CSR  = 5'b01111;
    localparam logic [4:0] FS_MUL  = 5'b10000;

    typedef enum logic {IDLE, MUL} state_t;

    state_t state, state_next;

    logic [WIDTH-1:0]    res;
    logic                c_new, o_new;
    logic [3:0]          flags_new;
    logic [WIDTH-1:0]    add_b;
    logic                add_cin;
    logic [WIDTH:0]      sum;
    logic                ovf;
    logic signed [WIDTH-1:0] a_signed;

    logic [WIDTH-1:0]    acc, acc_next;
    logic [WIDTH-1:0]    mcand;
    logic [MUL_ITER-1:0] mplier;
    logic [CNT_W-1:0]    cnt;
    logic                mul_wf;

    // Carry-out lands in bit WIDTH of the widened sum.
    function automatic logic [WIDTH:0] add_carry(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic             cin);
        return {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    endfunction

    assign add_b    = (FunSel == FS_SUB) ? ~B : B;
    assign add_cin  = (FunSel == FS_SUB) ? 1'b1 :
                      (FunSel == FS_ADC) ? FlagsOut[2] : 1'b0;
    assign sum      = add_carry(A, add_b, add_cin);
    assign ovf      = (A[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    assign a_signed = A;
    assign acc_next = mplier[0] ? (acc + mcand) : acc;

    always_comb begin
        res   = A;
        c_new = FlagsOut[2];
        o_new = FlagsOut[0];
        case (FunSel)
            FS_A:    res = A;
            FS_B:    res = B;
            FS_NA:   res = ~A;
            FS_NB:   res = ~B;
            FS_ADD, FS_ADC, FS_SUB: begin
                res   = sum[WIDTH-1:0];
                c_new = sum[WIDTH];
                o_new = ovf;
            end
            FS_AND:  res = A & B;
            FS_OR:   res = A | B;
            FS_XOR:  res = A ^ B;
            FS_NAND: res = ~(A & B);
            FS_LSL: begin
                res   = {A[WIDTH-2:0], 1'b0};
                c_new = A[WIDTH-1];
            end
            FS_LSR: begin
                res   = {1'b0, A[WIDTH-1:1]};
                c_new = A[0];
            end
            FS_ASR: begin
                res   = a_signed >>> 1;
                c_new = A[0];
            end
            FS_CSL: begin
                res   = {A[WIDTH-2:0], FlagsOut[2]};
                c_new = A[WIDTH-1];
            end
            FS_CSR: begin
                res   = {FlagsOut[2], A[WIDTH-1:1]};
                c_new = A[0];
            end
            default: res = A;
        endcase
        flags_new = {(res == '0), c_new, res[WIDTH-1], o_new};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start && FunSel == FS_MUL) state_next = MUL;
            MUL:  if (cnt == CNT_LAST)           state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operand latches isolate the multiplier from A/B/FunSel changes while busy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ALUOut   <= '0;
            FlagsOut <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            mul_wf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (FunSel == FS_MUL) begin
                            mcand  <= {{(WIDTH-MUL_ITER){1'b0}}, A[MUL_ITER-1:0]};
                            mplier <= B[MUL_ITER-1:0];
                            mul_wf <= WF;
                            acc    <= '0;
                            cnt    <= '0;
                            busy   <= 1'b1;
                        end else begin
                            ALUOut <= res;
                            if (WF) FlagsOut <= flags_new;
                            done   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        ALUOut <= acc_next;
                        if (mul_wf)
                            FlagsOut <= {(acc_next == '0), FlagsOut[2],
                                         acc_next[WIDTH-1], FlagsOut[0]};
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
